// File: rtl/wb_queue_if.sv
// Write-back queue bus: producer request, register-file write port, lookup port and occupancy.
// The slave modport is the queue's view; master is the producer/register-file side.
interface wb_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              drain_hold;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_addr, in_data, drain_hold, lookup_addr,
    input  in_ready, wr_en, wr_addr, wr_data, lookup_hit, lookup_data, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, drain_hold, lookup_addr,
    output in_ready, wr_en, wr_addr, wr_data, lookup_hit, lookup_data, count
  );
endinterface

// File: rtl/wb_queue.sv
// Write-back queue ahead of the register file write port, with youngest-match forwarding lookup.
// Latency: accept at edge N drives wr_* in cycle N+1; no bypass from empty. Optional: WB_QUEUE_XZR_DROP_EN.
// Backpressure: in_ready drops only when full (independent of same-cycle drain); drain_hold stalls the head.
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  wb_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             store;
  logic             drain;
  logic             not_empty;

  assign not_empty    = (cnt != '0);
  assign bus.in_ready = (cnt != CNT_W'(DEPTH));
  assign bus.count    = cnt;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = not_empty && !bus.drain_hold;

`ifdef WB_QUEUE_XZR_DROP_EN
  // Writes to the all-ones (zero) register are handshaken but never occupy an entry.
  assign store = accept && (bus.in_addr != {ADDR_W{1'b1}});
`else
  assign store = accept;
`endif

  assign bus.wr_en   = drain;
  assign bus.wr_addr = not_empty ? mem[head].addr : '0;
  assign bus.wr_data = not_empty ? mem[head].data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (store) tail <= tail + PTR_W'(1);
      if (drain) head <= head + PTR_W'(1);
      case ({store, drain})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: only entries counted as occupied are ever observed.
  always_ff @(posedge clk) begin
    if (store) mem[tail] <= '{addr: bus.in_addr, data: bus.in_data};
  end

  // Walk oldest to youngest so the last match (nearest the tail) wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx             = '0;
    bus.lookup_hit  = 1'b0;
    bus.lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < cnt) && (mem[idx].addr == bus.lookup_addr)) begin
        bus.lookup_hit  = 1'b1;
        bus.lookup_data = mem[idx].data;
      end
    end
  end
endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (DEPTH=4, DATA_W=32, ADDR_W=5).
// Honours WB_QUEUE_XZR_DROP_EN when selecting expectations for the zero-register case.
module tb_wb_queue;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  wb_queue_if #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) bus ();

  wb_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.drain_hold = 1'b1;
    push(5'd2, 32'h12);
    push(5'd6, 32'h34);
    checks++;
    if (bus.count !== 3'd2) begin
      errors++; $display("FAIL pre_reset_count got %0d want 2", bus.count);
    end
    bus.drain_hold = 1'b0;
    bus.lookup_addr = 5'd2;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.count !== 3'd0 || bus.wr_en !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset got count=%0d wr_en=%b in_ready=%b want 0 0 1",
                         bus.count, bus.wr_en, bus.in_ready);
    end
    checks++;
    if (bus.wr_addr !== 5'd0 || bus.wr_data !== 32'd0 || bus.lookup_hit !== 1'b0 ||
        bus.lookup_data !== 32'd0) begin
      errors++; $display("FAIL reset_outputs got addr=%0d data=%h hit=%b ldata=%h want all 0",
                         bus.wr_addr, bus.wr_data, bus.lookup_hit, bus.lookup_data);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.count !== 3'd0 || bus.wr_en !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got count=%0d wr_en=%b want 0 0", bus.count, bus.wr_en);
    end
  endtask

  task automatic test_fill_stall();
    bus.drain_hold = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 32'h11));
    checks++;
    if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full got count=%0d in_ready=%b want 4 0", bus.count, bus.in_ready);
    end
    checks++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== 5'd1 || bus.wr_data !== 32'h11) begin
      errors++; $display("FAIL held_head got en=%b addr=%0d data=%h want 0 1 11",
                         bus.wr_en, bus.wr_addr, bus.wr_data);
    end
    push(5'd5, 32'h55);
    checks++;
    if (bus.count !== 3'd4 || bus.wr_addr !== 5'd1) begin
      errors++; $display("FAIL fifth_push_refused got count=%0d head=%0d want 4 1", bus.count, bus.wr_addr);
    end
    bus.drain_hold = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'(k + 1) || bus.wr_data !== 32'((k + 1) * 32'h11)) begin
        errors++; $display("FAIL drain_order[%0d] got en=%b addr=%0d data=%h want 1 %0d %h",
                           k, bus.wr_en, bus.wr_addr, bus.wr_data, k + 1, (k + 1) * 32'h11);
      end
      tick();
    end
    checks++;
    if (bus.count !== 3'd0 || bus.wr_en !== 1'b0) begin
      errors++; $display("FAIL drained_empty got count=%0d wr_en=%b want 0 0", bus.count, bus.wr_en);
    end
  endtask

  task automatic test_streaming();
    bus.drain_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_addr  = 5'(i + 8);
      bus.in_data  = 32'h100 + 32'(i);
      tick();
      checks++;
      if (bus.count !== 3'd1 || bus.wr_en !== 1'b1 || bus.wr_addr !== 5'(i + 8) ||
          bus.wr_data !== 32'h100 + 32'(i)) begin
        errors++; $display("FAIL stream[%0d] got count=%0d en=%b addr=%0d data=%h want 1 1 %0d %h",
                           i, bus.count, bus.wr_en, bus.wr_addr, bus.wr_data, i + 8, 32'h100 + 32'(i));
      end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.count !== 3'd0) begin
      errors++; $display("FAIL stream_end got count=%0d want 0", bus.count);
    end
  endtask

  task automatic test_forwarding();
    bus.drain_hold = 1'b1;
    push(5'd7, 32'hA);
    push(5'd3, 32'hB);
    push(5'd7, 32'hC);
    bus.lookup_addr = 5'd7;
    #1;
    checks++;
    if (bus.lookup_hit !== 1'b1 || bus.lookup_data !== 32'hC) begin
      errors++; $display("FAIL fwd_youngest got hit=%b data=%h want 1 c", bus.lookup_hit, bus.lookup_data);
    end
    bus.lookup_addr = 5'd3;
    #1;
    checks++;
    if (bus.lookup_hit !== 1'b1 || bus.lookup_data !== 32'hB) begin
      errors++; $display("FAIL fwd_single got hit=%b data=%h want 1 b", bus.lookup_hit, bus.lookup_data);
    end
    bus.lookup_addr = 5'd5;
    #1;
    checks++;
    if (bus.lookup_hit !== 1'b0 || bus.lookup_data !== 32'h0) begin
      errors++; $display("FAIL fwd_miss got hit=%b data=%h want 0 0", bus.lookup_hit, bus.lookup_data);
    end
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd5;
    bus.in_data  = 32'h99;
    #1;
    checks++;
    if (bus.lookup_hit !== 1'b0) begin
      errors++; $display("FAIL fwd_incoming_not_searched got hit=%b want 0", bus.lookup_hit);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_full_drain();
    push(5'd9, 32'hD);
    bus.drain_hold = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_addr    = 5'd10;
    bus.in_data    = 32'hE;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd7 || bus.wr_data !== 32'hA) begin
      errors++; $display("FAIL full_drain_pre got rdy=%b en=%b addr=%0d data=%h want 0 1 7 a",
                         bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.count !== 3'd3 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL full_drain_post got count=%0d rdy=%b want 3 1", bus.count, bus.in_ready);
    end
    checks++;
    if (bus.wr_addr !== 5'd3 || bus.wr_data !== 32'hB) begin
      errors++; $display("FAIL full_drain_head2 got addr=%0d data=%h want 3 b", bus.wr_addr, bus.wr_data);
    end
    tick();
    checks++;
    if (bus.wr_addr !== 5'd7 || bus.wr_data !== 32'hC) begin
      errors++; $display("FAIL full_drain_head3 got addr=%0d data=%h want 7 c", bus.wr_addr, bus.wr_data);
    end
    tick();
    checks++;
    if (bus.wr_addr !== 5'd9 || bus.wr_data !== 32'hD) begin
      errors++; $display("FAIL full_drain_head4 got addr=%0d data=%h want 9 d", bus.wr_addr, bus.wr_data);
    end
    tick();
    checks++;
    if (bus.count !== 3'd0 || bus.wr_en !== 1'b0) begin
      errors++; $display("FAIL full_drain_empty got count=%0d en=%b want 0 0", bus.count, bus.wr_en);
    end
  endtask

  task automatic test_xzr();
    bus.drain_hold  = 1'b0;
    bus.lookup_addr = 5'd31;
    bus.in_valid    = 1'b1;
    bus.in_addr     = 5'd31;
    bus.in_data     = 32'hDEAD;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL xzr_ready got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
`ifdef WB_QUEUE_XZR_DROP_EN
    checks++;
    if (bus.count !== 3'd0 || bus.wr_en !== 1'b0 || bus.lookup_hit !== 1'b0) begin
      errors++; $display("FAIL xzr_dropped got count=%0d en=%b hit=%b want 0 0 0",
                         bus.count, bus.wr_en, bus.lookup_hit);
    end
`else
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd31 || bus.wr_data !== 32'hDEAD ||
        bus.lookup_hit !== 1'b1 || bus.lookup_data !== 32'hDEAD) begin
      errors++; $display("FAIL xzr_queued got en=%b addr=%0d data=%h hit=%b want 1 31 dead 1",
                         bus.wr_en, bus.wr_addr, bus.wr_data, bus.lookup_hit);
    end
`endif
    tick();
    checks++;
    if (bus.count !== 3'd0 || bus.wr_en !== 1'b0) begin
      errors++; $display("FAIL xzr_after got count=%0d en=%b want 0 0", bus.count, bus.wr_en);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_addr     = '0;
    bus.in_data     = '0;
    bus.drain_hold  = 1'b0;
    bus.lookup_addr = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_fill_stall();
    test_streaming();
    test_forwarding();
    test_full_drain();
    test_xzr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
# wb_queue

Write-back queue ahead of the register file write port. Accepts write requests (register index plus 32-bit value) from the execute/memory side and drains them one per clock into the register file's write enable, address and data inputs. This decouples producers from write-port stalls. A lookup port reports the youngest pending value for any register so that readers never see stale data while writes are queued.

## Interface

Parameters:
- DEPTH, 4: number of queue entries; power of two, 2..16.
- DATA_W, 32: data width.
- ADDR_W, 5: register index width.

Ports:
- clk, in, 1: single clock; all state changes on the rising edge.
- reset, in, 1: asynchronous, active-high; clears the queue immediately.
- in_valid, in, 1: write request present.
- in_ready, out, 1: queue can accept a request this cycle.
- in_addr, in, ADDR_W: destination register of the request.
- in_data, in, DATA_W: value to write.
- drain_hold, in, 1: when 1, the head entry is not drained this cycle.
- wr_en, out, 1: register file write enable.
- wr_addr, out, ADDR_W: register file write address.
- wr_data, out, DATA_W: register file write data.
- lookup_addr, in, ADDR_W: register index to search.
- lookup_hit, out, 1: a pending entry targets lookup_addr.
- lookup_data, out, DATA_W: data of the youngest matching pending entry; 0 when there is no hit.
- count, out, $clog2(DEPTH)+1: number of occupied entries.

## Operation

- Circular buffer with a head pointer, a tail pointer and an occupancy counter. Pointers wrap modulo DEPTH.
- Accept: the queue accepts a request when in_valid && in_ready. The entry is written at the tail and the tail advances.
- in_ready = (count != DEPTH). It does not depend on a same-cycle drain, so a full queue refuses input even while draining.
- Drain: wr_en = (count != 0) && !drain_hold. wr_addr and wr_data are the head entry. The head advances on the edge where wr_en=1.
- When count = 0, wr_addr and wr_data are 0.
- Simultaneous accept and drain: count is unchanged and both pointers advance.
- Lookup is combinational over occupied entries only. It returns the matching entry nearest the tail (youngest). The incoming request in the same cycle is not searched.
- Entries targeting the same register drain in arrival order. No coalescing.
- Reset asserted mid-operation: all pending entries are discarded. Nothing is written to the register file.

## Timing

- Reset values: in_ready=1, wr_en=0, wr_addr=0, wr_data=0, lookup_hit=0, lookup_data=0, count=0, pointers=0.
- Enqueue-to-write latency: a request accepted at edge N appears on wr_en/wr_addr/wr_data in cycle N+1 (after edge N), provided it is at the head and drain_hold=0. There is no same-cycle bypass from an empty queue.
- Throughput: one accept and one drain per cycle.
- count, in_ready, wr_* and lookup_* all reflect the state after the most recent edge.
- drain_hold may toggle every cycle. The head entry remains stable while held.

## Configuration

- WB_QUEUE_XZR_DROP_EN defined:
  - Requests with in_addr = all-ones (the zero register) are accepted (in_ready honoured) but not stored.
  - count and the pointers do not change for such requests.
  - lookup never hits for that index.
- WB_QUEUE_XZR_DROP_EN undefined: every request is queued and drained like any other, including those to the all-ones index.

## Test plan

- Reset then idle:
  - Assert reset asynchronously mid-cycle → count=0, wr_en=0, in_ready=1 immediately, without waiting for a clock.
- Fill and stall:
  - Stimulus: drain_hold=1; push addr 1..4 with data 0x11,0x22,0x33,0x44.
  - Response: after the 4th edge count=4, in_ready=0, and a 5th push is refused.
  - Then release drain_hold: wr_en=1 on 4 consecutive cycles with addr 1,2,3,4 in order; count returns to 0.
- Steady streaming:
  - Stimulus: drain_hold=0; push one request per cycle for 10 cycles.
  - Response: count stays at 1, and each value appears on wr_data exactly one cycle after its accept.
- Forwarding:
  - Stimulus: drain_hold=1; push (7,0xA), (3,0xB), (7,0xC); lookup_addr=7.
  - Response: lookup_hit=1 and lookup_data=0xC.
  - With lookup_addr=5: lookup_hit=0 and lookup_data=0.
- Full with simultaneous drain:
  - Stimulus: count=4, drain_hold=0, in_valid=1.
  - Response: in_ready=0 and no accept; after the edge count=3 and in_ready=1.
- XZR drop (macro defined):
  - Stimulus: push (31,0xDEAD) with an empty queue.
  - Response: in_ready=1, count stays 0, wr_en never asserts.
  - With the macro undefined, the same stimulus gives wr_en=1 with wr_addr=31 and wr_data=0xDEAD one cycle later.
